// File: rtl/puf_challenge_sequencer.sv
// -----------------------------------------------------------------------------
// puf_challenge_sequencer
//
// Purpose
//   Drives a 16-stage arbiter PUF without manual challenge entry. A 16-bit
//   Fibonacci LFSR supplies the challenge. Each evaluation runs this sequence:
//   clear the arbiter, launch, let the race settle, then sample the
//   synchronised response. A challenge is evaluated several times. The
//   majority-voted bit, the ones-count and the challenge are then offered on
//   a valid/ready output. When the consumer accepts the response, the LFSR
//   advances by one step.
//
// Build option
//   PUF_SEQ_MAJORITY_EN : when defined, each challenge is evaluated VOTES
//                         times and majority-voted. When undefined, a single
//                         evaluation is made, so resp_bit is the sampled bit
//                         and resp_ones is 0 or 1.
//
// Parameters
//   RESET_CYCLES  : cycles the arbiter clear is held per evaluation (>= 1)
//   SETTLE_CYCLES : cycles after launch before sampling (>= 3)
//   VOTES         : evaluations per challenge, odd, 1..255
//
// Ports
//   clk            in   system clock
//   reset          in   synchronous active-low reset
//   start          in   begin evaluating the current challenge (IDLE only)
//   seed_load      in   load seed into LFSR (IDLE only, beats start)
//   seed           in   LFSR seed; zero maps to 16'hACE1
//   challenge      out  challenge to arbiter, equals LFSR state
//   arb_in         out  arbiter launch
//   arb_reset      out  arbiter clear, active-high
//   puf_out        in   arbiter response, asynchronous
//   busy           out  high outside IDLE
//   resp_valid     out  response available
//   resp_ready     in   consumer accepts response
//   resp_bit       out  voted response bit
//   resp_ones      out  number of evaluations that sampled 1
//   resp_challenge out  challenge belonging to the response
// -----------------------------------------------------------------------------
module puf_challenge_sequencer #(
   parameter int RESET_CYCLES  = 4,
   parameter int SETTLE_CYCLES = 8,
   parameter int VOTES         = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        seed_load,
   input  logic [15:0] seed,
   output logic [0:15] challenge,
   output logic        arb_in,
   output logic        arb_reset,
   input  logic        puf_out,
   output logic        busy,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_bit,
   output logic [7:0]  resp_ones,
   output logic [0:15] resp_challenge
);

`ifdef PUF_SEQ_MAJORITY_EN
   localparam int EFF_VOTES = VOTES;
`else
   // Single evaluation. VOTES is still a parameter so both builds share
   // one interface.
   localparam int EFF_VOTES = (VOTES > 0) ? 1 : 1;
`endif

   localparam logic [15:0] LFSR_INIT   = 16'hACE1;
   localparam logic [7:0]  VOTES_LAST  = 8'(EFF_VOTES - 1);
   localparam logic [7:0]  VOTE_HALF   = 8'(EFF_VOTES / 2);
   localparam logic [15:0] CLEAR_LAST  = 16'(RESET_CYCLES - 1);
   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_LAUNCH = 3'd2,
      ST_SETTLE = 3'd3,
      ST_SAMPLE = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   // One LFSR step. x^16+x^14+x^13+x^11+1, shifting toward bit 15, with the
   // feedback entering bit 0.
   function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
      return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
   endfunction

   // A zero seed would lock the LFSR, so it is replaced by the init value.
   function automatic logic [15:0] seed_fix(input logic [15:0] sd);
      return (sd == 16'h0000) ? LFSR_INIT : sd;
   endfunction

   state_t      state_r;
   state_t      state_s;
   logic [15:0] timer_r;
   logic [7:0]  votes_r;
   logic [7:0]  ones_r;
   logic [15:0] lfsr_r;
   logic        sync1_r;
   logic        sync2_r;
   logic        handshake_s;
   logic        arb_reset_s;
   logic        arb_in_s;
   logic        busy_s;
   logic        arb_reset_r;
   logic        arb_in_r;
   logic        busy_r;
   logic        resp_valid_r;
   logic        resp_bit_r;
   logic [7:0]  resp_ones_r;
   logic [15:0] resp_challenge_r;

   // Next-state selection for the evaluation sequence.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (seed_load) begin
               state_s = ST_IDLE;
            end else if (start) begin
               state_s = ST_CLEAR;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            if (timer_r == CLEAR_LAST) begin
               state_s = ST_LAUNCH;
            end else begin
               state_s = ST_CLEAR;
            end
         end
         ST_LAUNCH: begin
            state_s = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (timer_r == SETTLE_LAST) begin
               state_s = ST_SAMPLE;
            end else begin
               state_s = ST_SETTLE;
            end
         end
         ST_SAMPLE: begin
            // votes_r counts completed samples, and this is the last one.
            if (votes_r == VOTES_LAST) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_CLEAR;
            end
         end
         ST_DONE: begin
            if (handshake_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Response handshake qualifier.
   always_comb begin
      handshake_s = 1'b0;
      if ((state_r == ST_DONE) && resp_valid_r && resp_ready) begin
         handshake_s = 1'b1;
      end else begin
         handshake_s = 1'b0;
      end
   end

   // Arbiter controls and busy, decoded from the next state so the
   // registered copies line up with the state register.
   always_comb begin
      arb_reset_s = 1'b1;
      arb_in_s    = 1'b0;
      busy_s      = 1'b0;
      case (state_s)
         ST_IDLE: begin
            arb_reset_s = 1'b1;
            arb_in_s    = 1'b0;
            busy_s      = 1'b0;
         end
         ST_CLEAR, ST_DONE: begin
            arb_reset_s = 1'b1;
            arb_in_s    = 1'b0;
            busy_s      = 1'b1;
         end
         ST_LAUNCH, ST_SETTLE, ST_SAMPLE: begin
            arb_reset_s = 1'b0;
            arb_in_s    = 1'b1;
            busy_s      = 1'b1;
         end
         default: begin
            arb_reset_s = 1'b1;
            arb_in_s    = 1'b0;
            busy_s      = 1'b0;
         end
      endcase
   end

   // State register plus the registered arbiter-facing outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         arb_reset_r <= 1'b1;
         arb_in_r    <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         arb_reset_r <= arb_reset_s;
         arb_in_r    <= arb_in_s;
         busy_r      <= busy_s;
      end
   end

   // Per-state cycle timer. It restarts whenever the state changes.
   always_ff @(posedge clk) begin
      if (!reset) begin
         timer_r <= 16'd0;
      end else if (state_s != state_r) begin
         timer_r <= 16'd0;
      end else begin
         timer_r <= timer_r + 16'd1;
      end
   end

   // Two-flop synchroniser for the asynchronous arbiter response.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= puf_out;
         sync2_r <= sync1_r;
      end
   end

   // Vote and ones counters. They are cleared when a run starts and bumped
   // once per sample.
   always_ff @(posedge clk) begin
      if (!reset) begin
         votes_r <= 8'd0;
         ones_r  <= 8'd0;
      end else if ((state_r == ST_IDLE) && (state_s == ST_CLEAR)) begin
         votes_r <= 8'd0;
         ones_r  <= 8'd0;
      end else if (state_r == ST_SAMPLE) begin
         votes_r <= votes_r + 8'd1;
         ones_r  <= ones_r + {7'd0, sync2_r};
      end else begin
         votes_r <= votes_r;
         ones_r  <= ones_r;
      end
   end

   // Challenge LFSR. It changes only on a seed load in IDLE or on an
   // accepted response.
   always_ff @(posedge clk) begin
      if (!reset) begin
         lfsr_r <= LFSR_INIT;
      end else if ((state_r == ST_IDLE) && seed_load) begin
         lfsr_r <= seed_fix(seed);
      end else if (handshake_s) begin
         lfsr_r <= lfsr_step(lfsr_r);
      end else begin
         lfsr_r <= lfsr_r;
      end
   end

   // Response registers. On the first DONE cycle they capture the final
   // counts, and then they hold. resp_valid drops on the handshake.
   always_ff @(posedge clk) begin
      if (!reset) begin
         resp_valid_r     <= 1'b0;
         resp_bit_r       <= 1'b0;
         resp_ones_r      <= 8'd0;
         resp_challenge_r <= 16'h0000;
      end else if ((state_r == ST_DONE) && !resp_valid_r) begin
         resp_valid_r     <= 1'b1;
         resp_bit_r       <= (ones_r > VOTE_HALF);
         resp_ones_r      <= ones_r;
         resp_challenge_r <= lfsr_r;
      end else if (handshake_s) begin
         resp_valid_r     <= 1'b0;
      end else begin
         resp_valid_r     <= resp_valid_r;
      end
   end

   assign challenge      = lfsr_r;
   assign arb_in         = arb_in_r;
   assign arb_reset      = arb_reset_r;
   assign busy           = busy_r;
   assign resp_valid     = resp_valid_r;
   assign resp_bit       = resp_bit_r;
   assign resp_ones      = resp_ones_r;
   assign resp_challenge = resp_challenge_r;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// -----------------------------------------------------------------------------
// tb_puf_challenge_sequencer
//
// Self-checking bench for puf_challenge_sequencer at its default parameters.
// A stand-in arbiter drives puf_out from a per-evaluation pattern each time
// arb_in rises. Expected values come from the pattern, a reference LFSR step,
// the configured vote count and the evaluation timing.
// -----------------------------------------------------------------------------
module tb_puf_challenge_sequencer;

   localparam int RC   = 4;
   localparam int SC   = 8;
   localparam int EVAL = RC + 1 + SC + 1;
`ifdef PUF_SEQ_MAJORITY_EN
   localparam int EFF = 15;
`else
   localparam int EFF = 1;
`endif
   localparam int LAT = 1 + EFF * EVAL;

   logic        clk;
   logic        reset;
   logic        start;
   logic        seed_load;
   logic [15:0] seed;
   logic [0:15] challenge;
   logic        arb_in;
   logic        arb_reset;
   logic        puf_out;
   logic        busy;
   logic        resp_valid;
   logic        resp_ready;
   logic        resp_bit;
   logic [7:0]  resp_ones;
   logic [0:15] resp_challenge;

   int n_cmp;
   int n_bad;
   bit puf_pat [0:255];
   int launch_idx;

   puf_challenge_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .seed_load(seed_load),
      .seed(seed), .challenge(challenge), .arb_in(arb_in),
      .arb_reset(arb_reset), .puf_out(puf_out), .busy(busy),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_bit(resp_bit), .resp_ones(resp_ones),
      .resp_challenge(resp_challenge)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in arbiter: each launch races to the next pattern value.
   always @(posedge arb_in) begin
      puf_out = (launch_idx < 256) ? puf_pat[launch_idx] : 1'b0;
      launch_idx++;
   end

   typedef struct {
      string       name;
      bit          do_seed;
      logic [15:0] seed;
      int          n_lead;
      int          ready_delay;
      logic [15:0] exp_chal;
      logic [15:0] exp_next;
      int          exp_ones;
      bit          exp_bit;
   } vec_t;

   vec_t tbl [6];

   function automatic logic [15:0] ref_next(input logic [15:0] v);
      int fb;
      fb = ((int'(v) >> 15) ^ (int'(v) >> 13) ^ (int'(v) >> 12) ^ (int'(v) >> 10)) & 1;
      return 16'(((int'(v) << 1) | fb) & 32'h0000FFFF);
   endfunction

   function automatic int min_i(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One complete challenge evaluation and handshake, with checks.
   task automatic do_run(input string nm, input bit do_seed, input logic [15:0] sd,
                         input int rdy_delay, input logic [15:0] exp_chal,
                         input logic [15:0] exp_next, input int exp_ones, input bit exp_bit);
      int cnt;
      int in_run;
      int rst_run;
      int launches;
      bit prev_in;
      if (do_seed) begin
         seed      = sd;
         seed_load = 1'b1;
         step();
         seed_load = 1'b0;
         chk({nm, "/seed_load"}, 32'(challenge), 32'(exp_chal));
      end
      launch_idx = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk({nm, "/busy_after_start"}, 32'(busy), 32'd1);
      cnt = 0; in_run = 0; rst_run = 0; launches = 0; prev_in = 1'b0;
      while (resp_valid !== 1'b1 && cnt < LAT + 40) begin
         if (arb_in && !prev_in) begin
            chk({nm, "/arb_reset_width"}, 32'(rst_run), 32'(RC));
            rst_run = 0;
            launches++;
         end
         if (!arb_in && prev_in) begin
            chk({nm, "/arb_in_width"}, 32'(in_run), 32'(1 + SC + 1));
            in_run = 0;
         end
         if (arb_in) in_run++;
         else if (busy && arb_reset) rst_run++;
         prev_in = arb_in;
         step();
         cnt++;
      end
      chk({nm, "/latency"}, 32'(cnt), 32'(LAT));
      chk({nm, "/launches"}, 32'(launches), 32'(EFF));
      chk({nm, "/resp_bit"}, 32'(resp_bit), 32'(exp_bit));
      chk({nm, "/resp_ones"}, 32'(resp_ones), 32'(exp_ones));
      chk({nm, "/resp_challenge"}, 32'(resp_challenge), 32'(exp_chal));
      chk({nm, "/challenge_held"}, 32'(challenge), 32'(exp_chal));
      for (int k = 0; k < rdy_delay; k++) begin
         start     = 1'($urandom_range(0, 1));
         seed_load = 1'($urandom_range(0, 1));
         seed      = 16'($urandom);
         step();
         chk({nm, "/stall_fields"}, {6'd0, resp_valid, resp_bit, resp_ones, resp_challenge},
             {6'd0, 1'b1, exp_bit, 8'(exp_ones), exp_chal});
         chk({nm, "/stall_challenge"}, 32'(challenge), 32'(exp_chal));
      end
      start      = 1'b0;
      seed_load  = 1'b0;
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      chk({nm, "/valid_drop"}, 32'(resp_valid), 32'd0);
      chk({nm, "/busy_idle"}, 32'(busy), 32'd0);
      chk({nm, "/next_challenge"}, 32'(challenge), 32'(exp_next));
   endtask

   initial begin
      logic [15:0] model_chal;
      logic [15:0] sd;
      logic [15:0] ec;
      bit          ds;
      int          ones;
      int          cnt;
      int          v;
      bit          seen;

      n_cmp = 0; n_bad = 0;
      reset = 1'b0; start = 1'b0; seed_load = 1'b0; seed = 16'h0000;
      resp_ready = 1'b0; puf_out = 1'b0; launch_idx = 0;

      tbl[0] = '{"seed0001_all1", 1'b1, 16'h0001, EFF, 0, 16'h0001, 16'h0002, EFF, 1'b1};
      tbl[1] = '{"lead7", 1'b0, 16'h0000, 7, 0, 16'h0002, 16'h0004,
                 min_i(7, EFF), (min_i(7, EFF) > EFF / 2)};
      tbl[2] = '{"lead8", 1'b0, 16'h0000, 8, 2, 16'h0004, 16'h0008,
                 min_i(8, EFF), (min_i(8, EFF) > EFF / 2)};
      tbl[3] = '{"seed0_all0", 1'b1, 16'h0000, 0, 3, 16'hACE1, 16'h59C3, 0, 1'b0};
      tbl[4] = '{"stall50", 1'b1, 16'h8000, EFF, 50, 16'h8000, 16'h0001, EFF, 1'b1};
      tbl[5] = '{"seed2400_lead1", 1'b1, 16'h2400, 1, 1, 16'h2400, 16'h4800, 1, (1 > EFF / 2)};

      // Reset state.
      repeat (2) step();
      chk("rst/challenge", 32'(challenge), 32'h0000ACE1);
      chk("rst/arb_in", 32'(arb_in), 32'd0);
      chk("rst/arb_reset", 32'(arb_reset), 32'd1);
      chk("rst/busy", 32'(busy), 32'd0);
      chk("rst/resp_valid", 32'(resp_valid), 32'd0);
      chk("rst/resp_bit", 32'(resp_bit), 32'd0);
      chk("rst/resp_ones", 32'(resp_ones), 32'd0);
      chk("rst/resp_challenge", 32'(resp_challenge), 32'd0);
      reset = 1'b1;
      step();

      // Table-driven runs.
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < 256; j++) puf_pat[j] = (j < tbl[i].n_lead);
         do_run(tbl[i].name, tbl[i].do_seed, tbl[i].seed, tbl[i].ready_delay,
                tbl[i].exp_chal, tbl[i].exp_next, tbl[i].exp_ones, tbl[i].exp_bit);
      end
      model_chal = 16'h4800;

      // Seed load beats start in the same cycle.
      seed = 16'h1234; seed_load = 1'b1; start = 1'b1;
      step();
      seed_load = 1'b0; start = 1'b0;
      chk("prio/busy", 32'(busy), 32'd0);
      chk("prio/challenge", 32'(challenge), 32'h00001234);
      step();
      chk("prio/still_idle", 32'(busy), 32'd0);
      model_chal = 16'h1234;

      // Randomised runs against the reference model.
      for (int r = 0; r < 6; r++) begin
         ds = ($urandom_range(0, 3) == 0);
         sd = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
         ec = ds ? ((sd == 16'h0000) ? 16'hACE1 : sd) : model_chal;
         ones = 0;
         for (int j = 0; j < 256; j++) begin
            puf_pat[j] = 1'($urandom_range(0, 1));
            if (j < EFF && puf_pat[j]) ones++;
         end
         do_run("rand", ds, sd, $urandom_range(0, 5), ec, ref_next(ec), ones, (ones > EFF / 2));
         model_chal = ref_next(ec);
      end

      // start held high chains two runs with one IDLE cycle between them.
      for (int j = 0; j < 256; j++) puf_pat[j] = 1'b1;
      launch_idx = 0;
      start = 1'b1;
      step();
      cnt = 0;
      while (resp_valid !== 1'b1 && cnt < LAT + 40) begin step(); cnt++; end
      chk("chain/latency", 32'(cnt), 32'(LAT));
      chk("chain/resp_challenge", 32'(resp_challenge), 32'(model_chal));
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      launch_idx = 0;
      model_chal = ref_next(model_chal);
      chk("chain/idle_gap", 32'(busy), 32'd0);
      chk("chain/next_challenge", 32'(challenge), 32'(model_chal));
      step();
      start = 1'b0;
      chk("chain/restart", 32'(busy), 32'd1);
      cnt = 0;
      while (resp_valid !== 1'b1 && cnt < LAT + 40) begin step(); cnt++; end
      chk("chain/second_resp_challenge", 32'(resp_challenge), 32'(model_chal));
      chk("chain/second_ones", 32'(resp_ones), 32'(EFF));
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      model_chal = ref_next(model_chal);
      chk("chain/third_challenge", 32'(challenge), 32'(model_chal));

      // Reset in SETTLE of vote 5 (vote 1 in single-evaluation builds).
      v = (EFF >= 5) ? 5 : 1;
      launch_idx = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (EVAL * (v - 1) + 8) step();
      chk("midrst/in_settle", {30'd0, arb_in, arb_reset}, {30'd0, 1'b1, 1'b0});
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("midrst/busy", 32'(busy), 32'd0);
      chk("midrst/arbiter", {30'd0, arb_in, arb_reset}, {30'd0, 1'b0, 1'b1});
      chk("midrst/resp_valid", 32'(resp_valid), 32'd0);
      chk("midrst/resp_ones", 32'(resp_ones), 32'd0);
      chk("midrst/challenge", 32'(challenge), 32'h0000ACE1);
      seen = 1'b0;
      repeat (LAT + 10) begin
         step();
         if (resp_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
      end
      chk("midrst/no_response", 32'(seen), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/puf_challenge_sequencer.md
# puf_challenge_sequencer

Drives the 16-stage arbiter PUF with a pseudo-random challenge, a clear/launch pulse sequence and a timed response sample, replacing manual VIO challenge entry. Sits directly upstream of the arbiter (feeds `Challenge`, `In`, `reset`) and consumes its `PUF_Out`. Evaluates each challenge repeatedly and presents a majority-voted response bit, its challenge and its ones-count on a valid/ready output.

## Interface
- `RESET_CYCLES`, 4 — cycles arbiter clear is held per evaluation (≥1)
- `SETTLE_CYCLES`, 8 — cycles after launch before sampling (≥3; covers 2-flop synchronizer)
- `VOTES`, 15 — evaluations per challenge; odd, 1..255
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  begin evaluating the current challenge (sampled in IDLE)
- `seed_load`  in  1  load `seed` into LFSR (sampled in IDLE)
- `seed`  in  16  LFSR seed
- `challenge`  out  [0:15]  challenge to arbiter; equals LFSR state
- `arb_in`  out  1  arbiter launch signal
- `arb_reset`  out  1  arbiter clear, active-high
- `puf_out`  in  1  arbiter response, asynchronous
- `busy`  out  1  high in any state except IDLE
- `resp_valid`  out  1  response available
- `resp_ready`  in  1  consumer accepts response
- `resp_bit`  out  1  voted response
- `resp_ones`  out  8  number of evaluations sampling 1
- `resp_challenge`  out  [0:15]  challenge belonging to response

## Operation
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, shifts toward index 15, feedback into bit 0. Reset value 16'hACE1. `seed_load` with `seed`=0 loads 16'hACE1 (no lockup).
- States: IDLE, CLEAR, LAUNCH, SETTLE, SAMPLE, DONE.
- IDLE: `arb_reset`=1, `arb_in`=0. `seed_load` has priority over `start` in the same cycle; `start` is then ignored. `start` → CLEAR, clears ones and vote counters.
- CLEAR: `arb_reset`=1, `arb_in`=0 for RESET_CYCLES → LAUNCH.
- LAUNCH: `arb_reset`=0, `arb_in`=1, one cycle → SETTLE.
- SETTLE: `arb_in`=1 held, SETTLE_CYCLES → SAMPLE.
- SAMPLE: ones += synchronized `puf_out` (2-flop); votes += 1; votes==VOTES → DONE, else CLEAR.
- DONE: `resp_valid`=1; `resp_bit` = (ones > VOTES/2), `resp_ones`, `resp_challenge` stable. On `resp_valid && resp_ready`: LFSR steps once, → IDLE.
- `challenge` stable from IDLE exit through DONE; changes only on seed load or handshake.
- `start`, `seed_load` outside IDLE ignored.
- Reset mid-operation: next cycle IDLE, counters 0, LFSR 16'hACE1, synchronizer cleared, no response emitted.

## Timing
- Reset values: `challenge`=16'hACE1, `arb_in`=0, `arb_reset`=1, `busy`=0, `resp_valid`=0, `resp_bit`=0, `resp_ones`=0, `resp_challenge`=0.
- One evaluation = RESET_CYCLES+1+SETTLE_CYCLES+1 cycles (defaults: 14).
- `start` sampled at edge N → `resp_valid` high after edge N+1+VOTES×14 (defaults: N+211).
- `resp_valid` holds with all response fields stable until accepted; no timeout.
- New `challenge` visible the cycle after handshake; `start` held high chains runs back-to-back with one IDLE cycle.

## Configuration
- `PUF_SEQ_MAJORITY_EN` defined: behaviour above, VOTES evaluations per challenge.
- Undefined: VOTES forced to 1; single evaluation; `resp_bit` = sampled value; `resp_ones` ∈ {0,1}; latency 1+14 cycles with defaults.

## Test plan
- Reset low 2 cycles → all outputs at reset values; `challenge`=16'hACE1, `busy`=0.
- `seed_load` with 16'h0001, then pulse `start` and accept result → `resp_challenge`=16'h0001, next `challenge`=16'h0002; `seed`=0 loads 16'hACE1.
- `puf_out` tied 1, `start` pulse → `resp_valid` exactly 211 cycles later, `resp_ones`=15, `resp_bit`=1; `arb_reset`/`arb_in` pulse widths 4/10 cycles per evaluation.
- `puf_out` = 1 on first 7 samples only → `resp_ones`=7, `resp_bit`=0; 8 samples → 8, 1.
- `resp_ready` low 50 cycles in DONE → `resp_valid` and fields stable, `challenge` unchanged; `start`/`seed_load` ignored.
- Reset asserted in SETTLE of vote 5 → IDLE next cycle, no `resp_valid`; macro undefined, `puf_out`=1 → `resp_ones`=1 after 15 cycles.
